// File: rtl/rom_prog_pkg.sv
// Shared constants and state encoding for the PROM programmer.
// Operation codes match the read path so both drive the same V1..V4 pins.
package rom_prog_pkg;

    localparam logic [3:0] OP_IDLE = 4'b0000;
    localparam logic [3:0] OP_READ = 4'b1100;
    localparam logic [3:0] OP_PROG = 4'b0011;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StPreread,
        StSetup,
        StPulse,
        StRecover,
        StVerify,
        StNextAddr,
        StDone,
        StError
    } state_t;

    // 556PT5 (3604): 8-bit x 512
    localparam int unsigned PT5_DATA_WIDTH    = 8;
    localparam int unsigned PT5_ADDRESS_WIDTH = 9;
    // 556PT4 (3601): 4-bit x 256
    localparam int unsigned PT4_DATA_WIDTH    = 4;
    localparam int unsigned PT4_ADDRESS_WIDTH = 8;

endpackage

// File: rtl/rom_prog_timer.sv
// Loadable down-counter shared by every timed programmer state.
// Loading N-1 on entry makes the state last exactly N cycles.
module rom_prog_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/rom_programmer.sv
// PROM write engine: per word pre-read, then per-bit Vpp pulse / recover / verify
// with bounded retries; drives the driver board and the shared address/op pins.
module rom_programmer
    import rom_prog_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDRESS_WIDTH  = 9,
    parameter int unsigned SETUP_CYCLES   = 16,
    parameter int unsigned PULSE_CYCLES   = 100,
    parameter int unsigned RECOVER_CYCLES = 16,
    parameter int unsigned MAX_RETRIES    = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [DATA_WIDTH-1:0]    s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_WIDTH-1:0]    data_line_in,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    output logic [3:0]               operation,
    output logic [DATA_WIDTH-1:0]    bit_select,
    output logic                     vpp_en,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [ADDRESS_WIDTH-1:0] error_address,
    output logic [DATA_WIDTH-1:0]    error_data
);

    localparam int unsigned MAX_SP  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_SP > RECOVER_CYCLES) ? MAX_SP : RECOVER_CYCLES;
    localparam int unsigned TW      = $clog2(MAX_CYC) + 1;
    localparam int unsigned RW      = $clog2(MAX_RETRIES) + 1;

    localparam logic [TW-1:0] T_SETUP   = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] T_PULSE   = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] T_RECOVER = TW'(RECOVER_CYCLES - 1);
    localparam logic [RW-1:0] R_MAX     = RW'(MAX_RETRIES);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST = '1;

    function automatic logic [DATA_WIDTH-1:0] lowest_bit(input logic [DATA_WIDTH-1:0] v);
        return v & (~v + DATA_WIDTH'(1));
    endfunction

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    word_q, word_d;
    logic [DATA_WIDTH-1:0]    pend_q, pend_d;
    logic [DATA_WIDTH-1:0]    cur_q, cur_d;
    logic [RW-1:0]            retry_q, retry_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic [ADDRESS_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [DATA_WIDTH-1:0]    err_data_q, err_data_d;
    logic [DATA_WIDTH-1:0]    remaining;
    logic                     tmr_load;
    logic [TW-1:0]            tmr_value;
    logic                     tmr_expired;

    rom_prog_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (tmr_load),
        .load_value(tmr_value),
        .expired   (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        word_d     = word_q;
        pend_d     = pend_q;
        cur_d      = cur_q;
        retry_d    = retry_q;
        done_d     = done_q;
        error_d    = error_q;
        err_addr_d = err_addr_q;
        err_data_d = err_data_q;
        remaining  = '0;
        tmr_load   = 1'b0;
        tmr_value  = T_SETUP;
        s_ready    = 1'b0;
        operation  = OP_IDLE;
        bit_select = '0;
        vpp_en     = 1'b0;
        busy       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d  = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                if (s_valid) begin
                    word_d   = s_data;
                    tmr_load = 1'b1;
                    state_d  = StPreread;
                end
            end
            StPreread: begin
                busy      = 1'b1;
                operation = OP_READ;
                if (tmr_expired) begin
                    // A blown fuse cannot be restored; a 1 where 0 is wanted is fatal.
                    if ((data_line_in & ~word_q) != '0) begin
                        error_d    = 1'b1;
                        err_addr_d = addr_q;
                        err_data_d = data_line_in;
                        state_d    = StError;
                    end else begin
                        remaining = word_q & ~data_line_in;
                        pend_d    = remaining;
                        if (remaining == '0) begin
                            state_d = StNextAddr;
                        end else begin
                            cur_d    = lowest_bit(remaining);
                            retry_d  = '0;
                            tmr_load = 1'b1;
                            state_d  = StSetup;
                        end
                    end
                end
            end
            StSetup: begin
                busy       = 1'b1;
                operation  = OP_PROG;
                bit_select = cur_q;
                if (tmr_expired) begin
                    tmr_load  = 1'b1;
                    tmr_value = T_PULSE;
                    retry_d   = retry_q + RW'(1);
                    state_d   = StPulse;
                end
            end
            StPulse: begin
                busy       = 1'b1;
                operation  = OP_PROG;
                bit_select = cur_q;
                vpp_en     = 1'b1;
                if (tmr_expired) begin
                    tmr_load  = 1'b1;
                    tmr_value = T_RECOVER;
                    state_d   = StRecover;
                end
            end
            StRecover: begin
                busy       = 1'b1;
                operation  = OP_PROG;
                bit_select = cur_q;
                if (tmr_expired) begin
                    tmr_load = 1'b1;
                    state_d  = StVerify;
                end
            end
            StVerify: begin
                busy      = 1'b1;
                operation = OP_READ;
                if (tmr_expired) begin
                    if ((data_line_in & cur_q) != '0) begin
                        remaining = pend_q & ~cur_q;
                        pend_d    = remaining;
                        if (remaining == '0) begin
                            state_d = StNextAddr;
                        end else begin
                            cur_d    = lowest_bit(remaining);
                            retry_d  = '0;
                            tmr_load = 1'b1;
                            state_d  = StSetup;
                        end
                    end else if (retry_q < R_MAX) begin
                        tmr_load = 1'b1;
                        state_d  = StSetup;
                    end else begin
                        error_d    = 1'b1;
                        err_addr_d = addr_q;
                        err_data_d = data_line_in;
                        state_d    = StError;
                    end
                end
            end
            StNextAddr: begin
                busy = 1'b1;
                if (addr_q == ADDR_LAST) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    addr_d  = addr_q + ADDRESS_WIDTH'(1);
                    state_d = StFetch;
                end
            end
            StDone, StError: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            word_q     <= '0;
            pend_q     <= '0;
            cur_q      <= '0;
            retry_q    <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
            err_data_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            pend_q     <= pend_d;
            cur_q      <= cur_d;
            retry_q    <= retry_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
            err_data_q <= err_data_d;
        end
    end

    assign address_line  = addr_q;
    assign done          = done_q;
    assign error         = error_q;
    assign error_address = err_addr_q;
    assign error_data    = err_data_q;

endmodule

// File: tb/tb_rom_programmer.sv
// Directed bench for rom_programmer against a fuse-array chip model with
// configurable pulses-to-blow per bit.
module tb_rom_programmer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] data_line_in;
    logic [8:0] address_line;
    logic [3:0] operation;
    logic [7:0] bit_select;
    logic       vpp_en;
    logic       busy;
    logic       done;
    logic       error;
    logic [8:0] error_address;
    logic [7:0] error_data;

    int checks = 0;
    int errors = 0;

    // Chip model state
    logic [7:0] cells [512];
    int         need [8];
    int         pcnt [8];
    logic [7:0] pbit [16];
    int         plen [16];
    int         n_pulses;
    int         hs_cnt;
    int         viol;
    int         run_len;
    logic       prev_vpp;
    logic [7:0] cur_bit;
    logic       poison;

    always #5 clk = ~clk;

    rom_programmer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .data_line_in (data_line_in),
        .address_line (address_line),
        .operation    (operation),
        .bit_select   (bit_select),
        .vpp_en       (vpp_en),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .error_address(error_address),
        .error_data   (error_data)
    );

    assign data_line_in = cells[address_line] | ((poison && address_line == 9'd7) ? 8'h80 : 8'h00);

    always @(posedge clk) begin
        prev_vpp <= vpp_en;
        if ((vpp_en && operation == 4'b1100) || (vpp_en && bit_select == 8'h00) ||
            (bit_select != 8'h00 && operation != 4'b0011)) begin
            viol <= viol + 1;
        end
        if (!reset_n) begin
            for (int i = 0; i < 512; i++) cells[i] <= 8'h00;
            for (int b = 0; b < 8; b++) pcnt[b] <= 0;
            n_pulses <= 0;
            hs_cnt   <= 0;
            run_len  <= 0;
        end else begin
            if (s_valid && s_ready) begin
                hs_cnt   <= hs_cnt + 1;
                n_pulses <= 0;
                for (int b = 0; b < 8; b++) pcnt[b] <= 0;
            end
            if (vpp_en) begin
                run_len <= prev_vpp ? run_len + 1 : 1;
                if (!prev_vpp) cur_bit <= bit_select;
            end else if (prev_vpp) begin
                if (n_pulses < 16) begin
                    plen[n_pulses] <= run_len;
                    pbit[n_pulses] <= cur_bit;
                end
                n_pulses <= n_pulses + 1;
                for (int b = 0; b < 8; b++) begin
                    if (cur_bit[b]) begin
                        pcnt[b] <= pcnt[b] + 1;
                        if (need[b] != 0 && pcnt[b] + 1 >= need[b]) begin
                            cells[address_line] <= cells[address_line] | cur_bit;
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clk);
            if (s_ready || !busy) break;
        end
        check({tag, "_timeout"}, 32'(i < bound), 32'd1);
    endtask

    task automatic send_word(input string tag, input logic [7:0] w);
        wait_ready(tag, 4000);
        s_data  = w;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b1;
        s_data  = 8'h00;
        s_valid = 1'b0;
        poison  = 1'b0;
        viol    = 0;
        for (int b = 0; b < 8; b++) need[b] = 1;

        // Reset with start held high: must have no effect
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        start   = 1'b0;
        check("rst_addr", 32'(address_line), 32'd0);
        check("rst_op", 32'(operation), 32'd0);
        check("rst_bitsel", 32'(bit_select), 32'd0);
        check("rst_vpp", 32'(vpp_en), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_err_addr", 32'(error_address), 32'd0);
        check("rst_err_data", 32'(error_data), 32'd0);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);

        // Blank chip, 0x05 at address 0: bits 0 then 2
        do_start();
        check("start_busy", 32'(busy), 32'd1);
        check("start_ready", 32'(s_ready), 32'd1);
        send_word("w05", 8'h05);
        wait_ready("w05_done", 4000);
        check("w05_npulse", 32'(n_pulses), 32'd2);
        check("w05_bit0", 32'(pbit[0]), 32'h01);
        check("w05_bit1", 32'(pbit[1]), 32'h04);
        check("w05_len0", 32'(plen[0]), 32'd100);
        check("w05_len1", 32'(plen[1]), 32'd100);
        check("w05_cell", 32'(cells[0]), 32'h05);
        check("w05_ready", 32'(s_ready), 32'd1);
        check("w05_addr", 32'(address_line), 32'd1);

        // 0x00 on a blank cell: no pulses
        send_word("w00", 8'h00);
        wait_ready("w00_done", 4000);
        check("w00_npulse", 32'(n_pulses), 32'd0);
        check("w00_addr", 32'(address_line), 32'd2);

        // Bit 1 needs three pulses
        need[1] = 3;
        send_word("w02a", 8'h02);
        wait_ready("w02a_done", 4000);
        check("retry3_npulse", 32'(n_pulses), 32'd3);
        check("retry3_bit", 32'(pbit[2]), 32'h02);
        check("retry3_cell", 32'(cells[2]), 32'h02);
        check("retry3_addr", 32'(address_line), 32'd3);
        check("retry3_err", 32'(error), 32'd0);

        // Bit 1 never sets: four pulses, then error
        need[1] = 0;
        send_word("w02b", 8'h02);
        wait_ready("w02b_done", 4000);
        check("never_npulse", 32'(n_pulses), 32'd4);
        check("never_error", 32'(error), 32'd1);
        check("never_busy", 32'(busy), 32'd0);
        check("never_err_addr", 32'(error_address), 32'd3);
        check("never_err_data", 32'(error_data), 32'h00);
        repeat (3) @(negedge clk);
        check("never_no_ready", 32'(s_ready), 32'd0);
        need[1] = 1;

        // Blown fuse at address 7 where 0 is wanted
        do_reset();
        do_start();
        check("restart_error_clr", 32'(error), 32'd0);
        for (int a = 0; a < 7; a++) send_word("fill", 8'h00);
        poison = 1'b1;
        send_word("w80", 8'h00);
        wait_ready("w80_done", 4000);
        check("blown_error", 32'(error), 32'd1);
        check("blown_npulse", 32'(n_pulses), 32'd0);
        check("blown_err_addr", 32'(error_address), 32'd7);
        check("blown_err_data", 32'(error_data), 32'h80);
        check("blown_done", 32'(done), 32'd0);
        poison = 1'b0;

        // Full 512-word run
        do_reset();
        do_start();
        for (int a = 0; a < 512; a++) send_word("full", 8'h00);
        wait_ready("full_done", 4000);
        check("full_done", 32'(done), 32'd1);
        check("full_error", 32'(error), 32'd0);
        check("full_busy", 32'(busy), 32'd0);
        check("full_addr", 32'(address_line), 32'd511);
        check("full_hs", 32'(hs_cnt), 32'd512);
        repeat (3) @(negedge clk);
        check("full_no_wrap", 32'(address_line), 32'd511);
        check("full_no_ready", 32'(s_ready), 32'd0);

        // Restart clears done; reset during PULSE
        do_start();
        check("rerun_done_clr", 32'(done), 32'd0);
        check("rerun_addr", 32'(address_line), 32'd0);
        send_word("w01", 8'h01);
        begin
            int i;
            for (i = 0; i < 500; i++) begin
                @(negedge clk);
                if (vpp_en) break;
            end
            check("pulse_seen", 32'(i < 500), 32'd1);
        end
        repeat (10) @(negedge clk);
        check("mid_pulse_vpp", 32'(vpp_en), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("rstpulse_vpp", 32'(vpp_en), 32'd0);
        check("rstpulse_busy", 32'(busy), 32'd0);
        check("rstpulse_bitsel", 32'(bit_select), 32'd0);
        check("rstpulse_op", 32'(operation), 32'd0);
        check("rstpulse_ready", 32'(s_ready), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        check("safety_invariants", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_programmer.md
Name: rom_programmer

Overview:
- Write-side counterpart to the PROM read path for 556PT5 (3604, 8-bit x 512) and 556PT4 (3601, 4-bit x 256) chips.
- Accepts target words from a host stream, one word per address, ascending from 0.
- For each word, pre-reads the cell, then programs each required bit individually: one-hot bit select, timed Vpp pulse, recovery, read-back verify, bounded retries.
- Drives the external high-voltage driver board and the same address/operation pins the read path uses.

Parameters:
- DATA_WIDTH, 8: data word width; 4 for 3601.
- ADDRESS_WIDTH, 9: address width; 8 for 3601.
- SETUP_CYCLES, 16: settle cycles before a pulse and before sampling a verify read.
- PULSE_CYCLES, 100: cycles vpp_en is held high per pulse.
- RECOVER_CYCLES, 16: cycles after the pulse with vpp_en low before verify.
- MAX_RETRIES, 4: maximum pulses per bit before error.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run at address 0; ignored while busy
- s_data  in  DATA_WIDTH  target word; 1 = fuse to blow
- s_valid  in  1  s_data valid
- s_ready  out  1  word accepted when s_valid && s_ready
- data_line_in  in  DATA_WIDTH  chip outputs, used for pre-read and verify
- address_line  out  ADDRESS_WIDTH  chip address
- operation  out  4  V1..V4 control code
- bit_select  out  DATA_WIDTH  one-hot bit under programming; 0 otherwise
- vpp_en  out  1  high-voltage pulse enable
- busy  out  1  run in progress
- done  out  1  sticky; all addresses programmed
- error  out  1  sticky; run aborted
- error_address  out  ADDRESS_WIDTH  address at which the error occurred
- error_data  out  DATA_WIDTH  chip readback at the error

Behaviour:
- Reset values: address_line=0, operation=OP_IDLE (4'b0000), bit_select=0, vpp_en=0, s_ready=0, busy=0, done=0, error=0, error_address=0, error_data=0, state=IDLE.
- OP_READ=4'b1100 (same code as the read path). OP_PROG=4'b0011.
- IDLE:
  - start -> FETCH; address_line=0; clear done and error; busy=1.
- FETCH:
  - s_ready=1; operation=OP_IDLE; vpp_en=0.
  - On handshake: latch word into pending mask -> PREREAD.
  - With s_valid low, remain in FETCH indefinitely.
- PREREAD:
  - operation=OP_READ; wait SETUP_CYCLES, then sample data_line_in as rb.
  - If rb & ~word != 0 (blown fuse where 0 is wanted) -> ERROR.
  - Otherwise pending = word & ~rb. If pending==0 -> NEXT_ADDR; else SETUP on the lowest set bit of pending, retry count=0.
- SETUP:
  - operation=OP_PROG; bit_select=that bit; vpp_en=0.
  - Lasts SETUP_CYCLES, then PULSE.
- PULSE:
  - vpp_en=1 for exactly PULSE_CYCLES consecutive cycles; retry count +1.
  - Then RECOVER.
- RECOVER:
  - vpp_en=0; bit_select held; RECOVER_CYCLES, then VERIFY.
- VERIFY:
  - operation=OP_READ; bit_select=0; sample after SETUP_CYCLES.
  - Bit reads 1: clear it in pending; next lowest pending bit -> SETUP with retry count=0; if none left -> NEXT_ADDR.
  - Bit reads 0 and retry count < MAX_RETRIES -> SETUP, same bit.
  - Bit reads 0 and retry count == MAX_RETRIES -> ERROR.
- NEXT_ADDR:
  - If address_line == 2^ADDRESS_WIDTH-1 -> DONE (no wrap).
  - Else address_line+1 -> FETCH.
- DONE: done=1, busy=0, outputs idle -> IDLE.
- ERROR:
  - error=1, busy=0; error_address=current address; error_data=last readback.
  - All drive outputs idle -> IDLE. No further words accepted.
- Safety invariants:
  - vpp_en=1 only in PULSE.
  - vpp_en and OP_READ are never asserted together.
  - bit_select is nonzero only in SETUP/PULSE/RECOVER.
- Reset mid-operation (including mid-PULSE): all outputs take reset values at the next clk edge; the partial word is discarded.
- Internal counters: one timer of width clog2(max(SETUP_CYCLES, PULSE_CYCLES, RECOVER_CYCLES))+1; retry counter of width clog2(MAX_RETRIES)+1.

Decomposition:
- Package rom_prog_pkg: OP_IDLE, OP_READ, OP_PROG constants; state enum (IDLE, FETCH, PREREAD, SETUP, PULSE, RECOVER, VERIFY, NEXT_ADDR, DONE, ERROR); chip-type defaults for 3604 and 3601.
- Sub-module rom_prog_timer: loadable down-counter with load value input, load strobe and expired flag; one instance shared by all timed states.

Test Plan:
- Reset held 3 cycles, then released -> all outputs at reset values; start while reset_n=0 -> no effect.
- Blank chip model, word 0x05 at addr 0 -> two pulses, bit_select 0x01 then 0x04; each vpp_en run exactly 100 cycles; then s_ready for addr 1.
- Word 0x00 on a blank cell -> no vpp_en activity; address advances after the pre-read.
- Model where bit 1 needs 3 pulses -> 3 pulses, then proceed. Model where bit 1 never sets -> 4 pulses, then error=1, error_address=current, error_data bit1=0.
- Chip reads 0x80 at addr 7, target 0x00 -> error with no pulse; error_address=7, error_data=0x80.
- Full 512-word run -> done=1 after addr 511, address_line does not wrap. Reset asserted during PULSE -> vpp_en=0 at the next edge; busy=0.
